// File: rtl/div_mod_x.sv
// Iterative DCPU-16 divide/modulo unit (DIV, DVI, MOD, MDI) with EX semantics.
// Restoring division of {|b|,16'h0} by |a|, one quotient bit per clock.
module div_mod_x (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] b,
   input  logic [15:0] a,
   output logic        busy,
   output logic        done,
   output logic [15:0] q,
   output logic [15:0] EX
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [1:0] OP_DIV = 2'b00;
   localparam logic [1:0] OP_DVI = 2'b01;
   localparam logic [1:0] OP_MOD = 2'b10;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] mag_a_q, mag_a_d;
   logic [31:0] dq_q, dq_d;     // dividend bits shift out the top, quotient bits shift in below
   logic [15:0] rem_q, rem_d;
   logic [15:0] rcap_q, rcap_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] res_q, res_d;
   logic [15:0] ex_q, ex_d;

   logic [15:0] abs_b, abs_a;
   logic [16:0] shifted;
   logic        fits;
   logic [15:0] trial, rem_next;
   logic [31:0] dq_next;
   logic [15:0] fin_q, fin_ex;

   // Magnitudes only for signed ops; 0x8000 negates to itself and is used as unsigned.
   assign abs_b = (op[0] && b[15]) ? (16'h0000 - b) : b;
   assign abs_a = (op[0] && a[15]) ? (16'h0000 - a) : a;

   assign shifted  = {rem_q, dq_q[31]};
   assign fits     = (shifted >= {1'b0, mag_a_q});
   assign trial    = shifted[15:0] - mag_a_q;
   assign rem_next = fits ? trial : shifted[15:0];
   assign dq_next  = {dq_q[30:0], fits};

   // Signed quotient: negating the high half alone truncates q toward zero,
   // while EX takes the low half of the full negated 32-bit quotient.
   always_comb begin
      fin_q  = dq_next[31:16];
      fin_ex = dq_next[15:0];
      case (op_q)
         OP_DIV: begin
            fin_q  = dq_next[31:16];
            fin_ex = dq_next[15:0];
         end
         OP_DVI: begin
            fin_q  = neg_q_q ? (16'h0000 - dq_next[31:16]) : dq_next[31:16];
            fin_ex = neg_q_q ? (16'h0000 - dq_next[15:0]) : dq_next[15:0];
         end
         OP_MOD: begin
            fin_q  = rcap_q;
            fin_ex = 16'h0000;
         end
         default: begin
            fin_q  = neg_r_q ? (16'h0000 - rcap_q) : rcap_q;
            fin_ex = 16'h0000;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mag_a_d = mag_a_q;
      dq_d    = dq_q;
      rem_d   = rem_q;
      rcap_d  = rcap_q;
      cnt_d   = cnt_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      res_d   = res_q;
      ex_d    = ex_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               mag_a_d = abs_a;
               dq_d    = {abs_b, 16'h0000};
               rem_d   = 16'h0000;
               rcap_d  = 16'h0000;
               cnt_d   = 5'd0;
               neg_q_d = op[0] & (b[15] ^ a[15]);
               neg_r_d = op[0] & b[15];
               if (a == 16'h0000) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  res_d   = 16'h0000;
                  ex_d    = 16'h0000;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            dq_d  = dq_next;
            rem_d = rem_next;
            cnt_d = cnt_q + 5'd1;
            // After the 16th iteration all dividend bits of b are consumed.
            if (cnt_q == 5'd15) begin
               rcap_d = rem_next;
            end
            if (cnt_q == 5'd31) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               res_d   = fin_q;
               ex_d    = fin_ex;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 2'b00;
         mag_a_q <= 16'h0000;
         dq_q    <= 32'h0000_0000;
         rem_q   <= 16'h0000;
         rcap_q  <= 16'h0000;
         cnt_q   <= 5'd0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= 16'h0000;
         ex_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mag_a_q <= mag_a_d;
         dq_q    <= dq_d;
         rem_q   <= rem_d;
         rcap_q  <= rcap_d;
         cnt_q   <= cnt_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         res_q   <= res_d;
         ex_q    <= ex_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign q    = res_q;
   assign EX   = ex_q;

endmodule

// File: tb/tb_div_mod_x.sv
// Directed vector bench for div_mod_x: results, latency, busy behaviour,
// ignored starts and asynchronous abort.
module tb_div_mod_x;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] b;
   logic [15:0] a;
   logic        busy;
   logic        done;
   logic [15:0] q;
   logic [15:0] EX;

   int total = 0;
   int bad   = 0;

   div_mod_x dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .b     (b),
      .a     (a),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .EX    (EX)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] b;
      logic [15:0] a;
      logic [15:0] eq;
      logic [15:0] eex;
      int          lat;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int cyc;
      bit got;
      bit seen_busy;
      @(posedge clk); #1;
      start = 1'b1; op = v.op; b = v.b; a = v.a;
      @(posedge clk); #1;
      start = 1'b0; op = ~v.op; b = ~v.b; a = 16'h5A5A;
      cyc = 1; got = 1'b0; seen_busy = 1'b0;
      while (cyc <= 40 && !got) begin
         if (busy) seen_busy = 1'b1;
         if (done) got = 1'b1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk({nm, "_done"}, 32'(got), 32'd1);
      chk({nm, "_lat"}, 32'(cyc), 32'(v.lat));
      chk({nm, "_q"}, 32'(q), 32'(v.eq));
      chk({nm, "_ex"}, 32'(EX), 32'(v.eex));
      chk({nm, "_busyseen"}, 32'(seen_busy), (v.lat == 1) ? 32'd0 : 32'd1);
      chk({nm, "_busyatdone"}, 32'(busy), 32'd0);
      $display("vec %s op=%0d b=%h a=%h -> q=%h EX=%h lat=%0d", nm, v.op, v.b, v.a, q, EX, cyc);
   endtask

   initial begin
      int cyc;
      int ndone;
      bit got;

      vecs[0]  = '{2'b00, 16'h0007, 16'h0002, 16'h0003, 16'h8000, 33};
      vecs[1]  = '{2'b01, 16'hFFF9, 16'h0002, 16'hFFFD, 16'h8000, 33};
      vecs[2]  = '{2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'h0000, 33};
      vecs[3]  = '{2'b11, 16'hFFF9, 16'h0010, 16'hFFF9, 16'h0000, 33};
      vecs[4]  = '{2'b10, 16'h0007, 16'h0002, 16'h0001, 16'h0000, 33};
      vecs[5]  = '{2'b10, 16'h1234, 16'h0100, 16'h0034, 16'h0000, 33};
      vecs[6]  = '{2'b01, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 33};
      vecs[7]  = '{2'b00, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 33};
      vecs[8]  = '{2'b00, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1};
      vecs[9]  = '{2'b01, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1};
      vecs[10] = '{2'b10, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1};
      vecs[11] = '{2'b11, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 1};
      vecs[12] = '{2'b01, 16'h0064, 16'hFFF9, 16'hFFF2, 16'hB6DC, 33};
      vecs[13] = '{2'b11, 16'h0064, 16'hFFF9, 16'h0002, 16'h0000, 33};
      vecs[14] = '{2'b11, 16'hFF9C, 16'h0007, 16'hFFFE, 16'h0000, 33};
      vecs[15] = '{2'b10, 16'hFFFF, 16'h0010, 16'h000F, 16'h0000, 33};
      vecs[16] = '{2'b00, 16'h1234, 16'h0100, 16'h0012, 16'h3400, 33};
      vecs[17] = '{2'b01, 16'hFFF9, 16'hFFFE, 16'h0003, 16'h8000, 33};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; b = 16'h0000; a = 16'h0000;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_ex", 32'(EX), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // start pulsed mid-RUN and again on the done cycle must both be ignored
      @(posedge clk); #1;
      start = 1'b1; op = 2'b00; b = 16'h0007; a = 16'h0002;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; ndone = 0; got = 1'b0;
      repeat (4) begin @(posedge clk); #1; cyc++; end
      start = 1'b1; op = 2'b00; b = 16'hFFFF; a = 16'h0001;
      @(posedge clk); #1; cyc++;
      start = 1'b0;
      while (cyc <= 40 && !got) begin
         if (done) got = 1'b1;
         else begin @(posedge clk); #1; cyc++; end
      end
      chk("ign_lat", 32'(cyc), 32'd33);
      chk("ign_q", 32'(q), 32'h0003);
      chk("ign_ex", 32'(EX), 32'h8000);
      start = 1'b1; op = 2'b00; b = 16'hBEEF; a = 16'h0000;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done) ndone++;
         if (busy) ndone++;
         @(posedge clk); #1;
      end
      chk("ign_nomore", 32'(ndone), 32'd0);
      chk("ign_q_held", 32'(q), 32'h0003);
      $display("seq ignore-start q=%h EX=%h", q, EX);

      // asynchronous abort at cycle 10 of RUN
      start = 1'b1; op = 2'b00; b = 16'h0007; a = 16'h0002;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q", 32'(q), 32'd0);
      chk("abort_ex", 32'(EX), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      chk("abort_nodone", 32'(ndone), 32'd0);
      $display("seq abort busy=%b done=%b q=%h EX=%h", busy, done, q, EX);

      run_vec(vecs[0], "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
